// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared memory with a mem_ready handshake, plus a sticky illegal-instruction trap.
`timescale 1ns/1ps
module multicycle_controller #(
  parameter int unsigned ALU_CTRL_W    = 32'd3,
  parameter bit          SUPPORT_ITYPE = 1'b1,
  parameter bit          SUPPORT_BNE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            imm_src,
  output logic                  reg_write,
  output logic                  trap
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic       pc_write_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       trap_s;
  logic [2:0] alu_s;
  logic       unused_funct7_s;

  assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

  // sub is only selected for R-type funct7[5]=1; I-type has op[5]=0
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic op5, input logic f75);
    case (f3)
      3'b000:  alu_decode = (op5 & f75) ? 3'b001 : 3'b000;
      3'b010:  alu_decode = 3'b101;
      3'b110:  alu_decode = 3'b011;
      3'b111:  alu_decode = 3'b010;
      default: alu_decode = 3'b000;
    endcase
  endfunction

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state logic
  always_comb begin
    next_state_s = S_TRAP;
    case (state_r)
      S_FETCH:    next_state_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: next_state_s = S_MEMADR;
          7'b0110011:             next_state_s = S_EXECUTER;
          7'b0010011:             next_state_s = SUPPORT_ITYPE ? S_EXECUTEI : S_TRAP;
          7'b1101111:             next_state_s = S_JAL;
          7'b1100011: begin
            if ((funct3 == 3'b000) || ((funct3 == 3'b001) && SUPPORT_BNE)) begin
              next_state_s = S_BRANCH;
            end else begin
              next_state_s = S_TRAP;
            end
          end
          default:                next_state_s = S_TRAP;
        endcase
      end
      S_MEMADR:   next_state_s = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state_s = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: next_state_s = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: next_state_s = S_ALUWB;
      S_EXECUTEI: next_state_s = S_ALUWB;
      S_ALUWB:    next_state_s = S_FETCH;
      S_JAL:      next_state_s = S_ALUWB;
      S_BRANCH:   next_state_s = S_FETCH;
      S_TRAP:     next_state_s = S_TRAP;
      default:    next_state_s = S_TRAP;
    endcase
  end

  // per-state control outputs
  always_comb begin
    pc_write_s  = 1'b0;
    adr_src     = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_s       = 3'b000;
    reg_write_s = 1'b0;
    trap_s      = 1'b0;
    case (state_r)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_s     = alu_decode(funct3, op[5], funct7[5]);
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_s     = alu_decode(funct3, op[5], funct7[5]);
      end
      S_ALUWB:    reg_write_s = 1'b1;
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_s     = 3'b001;
        if (funct3 == 3'b000) begin
          pc_write_s = zero;
        end else if (funct3 == 3'b001) begin
          pc_write_s = ~zero;
        end else begin
          pc_write_s = 1'b0;
        end
      end
      S_TRAP:     trap_s = 1'b1;
      default:    trap_s = 1'b1;
    endcase
  end

  // immediate format depends only on the opcode
  always_comb begin
    case (op)
      7'b0100011: imm_src = 2'b01;
      7'b1100011: imm_src = 2'b10;
      7'b1101111: imm_src = 2'b11;
      default:    imm_src = 2'b00;
    endcase
  end

  // enables are held off for the whole time reset is asserted
  assign pc_write    = rst_n & pc_write_s;
  assign mem_write   = rst_n & mem_write_s;
  assign ir_write    = rst_n & ir_write_s;
  assign reg_write   = rst_n & reg_write_s;
  assign trap        = rst_n & trap_s;
  assign alu_control = ALU_CTRL_W'(alu_s);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its states
// and compares the full output vector every cycle against hand-written expectations.
`timescale 1ns/1ps
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, trap;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       nb_pc_write, nb_adr_src, nb_mem_write, nb_ir_write, nb_reg_write, nb_trap;
  logic [1:0] nb_result_src, nb_alu_src_a, nb_alu_src_b, nb_imm_src;
  logic [2:0] nb_alu_control;

  logic [16:0] obs, obs_nb;
  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .reg_write(reg_write), .trap(trap)
  );

  multicycle_controller #(.SUPPORT_BNE(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
    .mem_ready(mem_ready), .pc_write(nb_pc_write), .adr_src(nb_adr_src), .mem_write(nb_mem_write),
    .ir_write(nb_ir_write), .result_src(nb_result_src), .alu_src_a(nb_alu_src_a),
    .alu_src_b(nb_alu_src_b), .alu_control(nb_alu_control), .imm_src(nb_imm_src),
    .reg_write(nb_reg_write), .trap(nb_trap)
  );

  always #5 clk = ~clk;

  assign obs    = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                   alu_control, imm_src, reg_write, trap};
  assign obs_nb = {nb_pc_write, nb_adr_src, nb_mem_write, nb_ir_write, nb_result_src, nb_alu_src_a,
                   nb_alu_src_b, nb_alu_control, nb_imm_src, nb_reg_write, nb_trap};

  // {pc_write, adr_src, mem_write, ir_write, result_src, a, b, alu, imm, reg_write, trap}
  function automatic logic [16:0] ov(input logic pcw, input logic adr, input logic mw, input logic irw,
                                     input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] alu, input logic [1:0] imm,
                                     input logic rw, input logic tr);
    ov = {pcw, adr, mw, irw, rs, a, b, alu, imm, rw, tr};
  endfunction

  function automatic logic [16:0] fetch_v(input logic mr, input logic [1:0] imm);
    fetch_v = ov(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0);
  endfunction

  function automatic logic [16:0] decode_v(input logic [1:0] imm);
    decode_v = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, 1'b0);
  endfunction

  task automatic chk_now(input string tag, input logic [16:0] exp, input logic [16:0] exp_nb,
                         input logic both);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
    if (both) begin
      checks++;
      assert (obs_nb === exp_nb) else begin
        errors++;
        $error("FAIL %s_nb observed %h expected %h", tag, obs_nb, exp_nb);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [16:0] exp);
    @(negedge clk);
    chk_now(tag, exp, 17'd0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk2(input string tag, input logic [16:0] exp, input logic [16:0] exp_nb);
    @(negedge clk);
    chk_now(tag, exp, exp_nb, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7 = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk_now("reset", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0),
            ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0), 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // lw: 5 cycles
    chk("lw_fetch", fetch_v(1'b1, 2'b00));
    chk("lw_decode", decode_v(2'b00));
    chk("lw_memadr", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0));
    chk("lw_memread", ov(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
    chk("lw_memwb", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0));

    // sw with two wait cycles in MEMWRITE
    op = 7'b0100011;
    chk("sw_fetch", fetch_v(1'b1, 2'b01));
    chk("sw_decode", decode_v(2'b01));
    chk("sw_memadr", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0, 1'b0));
    mem_ready = 1'b0;
    chk("sw_wait1", ov(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0));
    chk("sw_wait2", ov(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0));
    mem_ready = 1'b1;
    chk("sw_done", ov(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0));

    // R-type sub
    op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000;
    chk("sub_fetch", fetch_v(1'b1, 2'b00));
    chk("sub_decode", decode_v(2'b00));
    chk("sub_exec", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0));
    chk("sub_aluwb", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0));

    // R-type add
    funct7 = 7'd0;
    chk("add_fetch", fetch_v(1'b1, 2'b00));
    chk("add_decode", decode_v(2'b00));
    chk("add_exec", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
    chk("add_aluwb", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0));

    // addi with funct7[5] set must still add
    op = 7'b0010011; funct7 = 7'b0100000;
    chk("addi_fetch", fetch_v(1'b1, 2'b00));
    chk("addi_decode", decode_v(2'b00));
    chk("addi_exec", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0));
    chk("addi_aluwb", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0));

    // slt (R-type)
    op = 7'b0110011; funct3 = 3'b010; funct7 = 7'd0;
    chk("slt_fetch", fetch_v(1'b1, 2'b00));
    chk("slt_decode", decode_v(2'b00));
    chk("slt_exec", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00, 1'b0, 1'b0));
    chk("slt_aluwb", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0));

    // andi
    op = 7'b0010011; funct3 = 3'b111;
    chk("andi_fetch", fetch_v(1'b1, 2'b00));
    chk("andi_decode", decode_v(2'b00));
    chk("andi_exec", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0));
    chk("andi_aluwb", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0));

    // jal
    op = 7'b1101111; funct3 = 3'b000;
    chk("jal_fetch", fetch_v(1'b1, 2'b11));
    chk("jal_decode", decode_v(2'b11));
    chk("jal_jal", ov(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 1'b0, 1'b0));
    chk("jal_aluwb", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1'b1, 1'b0));

    // beq taken / not taken
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    chk("beq1_fetch", fetch_v(1'b1, 2'b10));
    chk("beq1_decode", decode_v(2'b10));
    chk("beq1_branch", ov(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0, 1'b0));
    zero = 1'b0;
    chk("beq0_fetch", fetch_v(1'b1, 2'b10));
    chk("beq0_decode", decode_v(2'b10));
    chk("beq0_branch", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0, 1'b0));

    // bne: taken on the full build, trap when bne is not supported
    funct3 = 3'b001;
    chk2("bne_fetch", fetch_v(1'b1, 2'b10), fetch_v(1'b1, 2'b10));
    chk2("bne_decode", decode_v(2'b10), decode_v(2'b10));
    chk2("bne_branch", ov(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0, 1'b0),
         ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10, 1'b0, 1'b1));

    // illegal opcode: sticky trap
    op = 7'b0000000; funct3 = 3'b000;
    chk("ill_fetch", fetch_v(1'b1, 2'b00));
    chk("ill_decode", decode_v(2'b00));
    for (int i = 0; i < 10; i++) begin
      chk("ill_trap", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1));
    end

    // asynchronous reset away from the clock edge
    rst_n = 1'b0;
    #1;
    chk_now("async_reset", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0),
            ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0), 1'b1);
    #1;
    rst_n = 1'b1;

    // FETCH stalls while memory is not ready
    op = 7'b0110011; mem_ready = 1'b0;
    chk2("stall1", fetch_v(1'b0, 2'b00), fetch_v(1'b0, 2'b00));
    chk("stall2", fetch_v(1'b0, 2'b00));
    chk("stall3", fetch_v(1'b0, 2'b00));
    mem_ready = 1'b1;
    chk("stall_go", fetch_v(1'b1, 2'b00));
    chk("stall_decode", decode_v(2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
